// File: rtl/bus_mem_slave_if.sv
// bus_mem_slave_if: request/response bus between a master and the memory slave.
interface bus_mem_slave_if;
  logic        i_bus_en;
  logic        i_wr_en;
  logic [31:0] i_addr;
  logic [31:0] i_wr_data;
  logic [3:0]  i_byte_en;
  logic [31:0] o_rd_data;
  logic        o_ack;
  logic        o_err;
  logic        o_busy;
  modport slave (
    input  i_bus_en, i_wr_en, i_addr, i_wr_data, i_byte_en,
    output o_rd_data, o_ack, o_err, o_busy
  );
  modport master (
    output i_bus_en, i_wr_en, i_addr, i_wr_data, i_byte_en,
    input  o_rd_data, o_ack, o_err, o_busy
  );
endinterface

// File: rtl/bus_mem_slave.sv
// bus_mem_slave: word memory behind a wait-stated bus with byte-lane writes and range checking.
module bus_mem_slave #(
  parameter int          MEM_WORDS   = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  bus_mem_slave_if.slave bus
);
  localparam int          IW        = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      r_state, w_state_nx;
  logic [3:0]  r_cnt, w_cnt_nx;
  logic        r_wr, r_err;
  logic [31:0] r_addr, r_wdata, r_rd_data;
  logic [3:0]  r_be;
  logic [31:0] r_mem [MEM_WORDS];
  logic        w_idle, w_wr, w_in_range, w_enter_resp;
  logic [31:0] w_addr, w_wdata, w_off;
  logic [3:0]  w_be;
  logic [IW-1:0] w_idx;
  // In IDLE the live inputs are the request; this lets a zero-wait slave commit on the accepting edge.
  assign w_idle       = r_state == IDLE;
  assign w_wr         = w_idle ? bus.i_wr_en : r_wr;
  assign w_addr       = w_idle ? bus.i_addr : r_addr;
  assign w_wdata      = w_idle ? bus.i_wr_data : r_wdata;
  assign w_be         = w_idle ? bus.i_byte_en : r_be;
  assign w_off        = w_addr - BASE_ADDR;
  assign w_in_range   = w_off < MEM_BYTES;
  assign w_idx        = w_off[IW+1:2];
  assign w_enter_resp = (w_state_nx == RESP) && (r_state != RESP);
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_err     <= 1'b0;
      r_rd_data <= 32'd0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (w_enter_resp) begin
        r_err <= !w_in_range;
        if (!w_in_range) r_rd_data <= 32'hDEAD_BEEF;
        else if (!w_wr) r_rd_data <= r_mem[w_idx];
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (w_idle) begin
      r_wr    <= bus.i_wr_en;
      r_addr  <= bus.i_addr;
      r_wdata <= bus.i_wr_data;
      r_be    <= bus.i_byte_en;
    end
  end
  // Memory is never reset; a reset edge suppresses the commit so a pending write is dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst && w_enter_resp && w_wr && w_in_range)
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
  end
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    if (r_state == IDLE && bus.i_bus_en) begin
      w_state_nx = (WAIT_CYCLES == 0) ? RESP : WAIT;
      w_cnt_nx   = 4'(WAIT_CYCLES);
    end else if (r_state == WAIT) begin
      w_state_nx = !bus.i_bus_en ? IDLE : (r_cnt == 4'd1) ? RESP : WAIT;
      w_cnt_nx   = bus.i_bus_en ? r_cnt - 4'd1 : 4'd0;
    end else if (r_state == RESP) begin
      w_state_nx = IDLE;
      w_cnt_nx   = 4'd0;
    end
  end
  always_comb begin
    bus.o_ack     = r_state == RESP;
    bus.o_busy    = r_state != IDLE;
    bus.o_err     = (r_state == RESP) && r_err;
    bus.o_rd_data = r_rd_data;
  end
endmodule

// File: tb/tb_bus_mem_slave.sv
// tb_bus_mem_slave: directed checks of bus_mem_slave with default parameters (4096 words, base 0, 2 waits).
module tb_bus_mem_slave;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int errors = 0;
  logic [31:0] last_rd = 32'd0;
  bus_mem_slave_if bus();
  bus_mem_slave dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic xact(input string tag, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, output int lat, output logic [31:0] rd, output logic er);
    @(negedge clk);
    bus.i_bus_en = 1'b1; bus.i_wr_en = wr; bus.i_addr = a; bus.i_wr_data = d; bus.i_byte_en = be;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (bus.o_ack !== 1'b1 && lat < 20);
    rd = bus.o_rd_data;
    er = bus.o_err;
    bus.i_bus_en = 1'b0;
    @(posedge clk); #1;
    check({tag, "_ack_pulse"}, 32'(bus.o_ack), 32'd0);
  endtask

  task automatic run(input string tag, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input logic exp_err, input logic [31:0] exp_rd, input logic chk_rd);
    int lat;
    logic [31:0] rd;
    logic er;
    xact(tag, wr, a, d, be, lat, rd, er);
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_err"}, 32'(er), 32'(exp_err));
    if (chk_rd) check({tag, "_rd"}, rd, exp_rd);
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    run(tag, 1'b1, a, d, be, 1'b0, last_rd, 1'b1);
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    run(tag, 1'b0, a, 32'd0, 4'd0, 1'b0, exp, 1'b1);
    last_rd = exp;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acks;
    bus.i_bus_en = 1'b0; bus.i_wr_en = 1'b0; bus.i_addr = 32'd0; bus.i_wr_data = 32'd0; bus.i_byte_en = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(bus.o_ack), 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_err", 32'(bus.o_err), 32'd0);
    check("rst_rd", bus.o_rd_data, 32'd0);
    @(negedge clk) rst = 1'b1;

    wr("w_cafe", 32'h10, 32'hCAFE_F00D, 4'hF);
    rd("r_cafe", 32'h10, 32'hCAFE_F00D);

    wr("w_1122", 32'h20, 32'h1122_3344, 4'hF);
    wr("w_lane", 32'h20, 32'hAABB_CCDD, 4'b0101);
    rd("r_lane", 32'h20, 32'h11BB_33DD);
    wr("w_be0", 32'h20, 32'hFFFF_FFFF, 4'b0000);
    rd("r_be0", 32'h20, 32'h11BB_33DD);

    wr("w_a5", 32'h10, 32'h0000_00A5, 4'hF);
    rd("r_unal", 32'h13, 32'h0000_00A5);

    wr("w_word0", 32'h0, 32'h5A5A_0000, 4'hF);
    run("r_oor", 1'b0, 32'h4000, 32'd0, 4'd0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    run("w_oor", 1'b1, 32'h4000, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'd0, 1'b0);
    rd("r_word0", 32'h0, 32'h5A5A_0000);

    wr("w_30", 32'h30, 32'h1234_5678, 4'hF);
    @(negedge clk);
    bus.i_bus_en = 1'b1; bus.i_wr_en = 1'b1; bus.i_addr = 32'h30; bus.i_wr_data = 32'h0000_0BAD; bus.i_byte_en = 4'hF;
    @(posedge clk); #1;
    check("abort_busy", 32'(bus.o_busy), 32'd1);
    @(negedge clk) bus.i_bus_en = 1'b0;
    acks = 0;
    repeat (4) begin @(posedge clk); #1; if (bus.o_ack === 1'b1) acks++; end
    check("abort_no_ack", 32'(acks), 32'd0);
    check("abort_idle", 32'(bus.o_busy), 32'd0);
    rd("r_abort", 32'h30, 32'h1234_5678);

    @(negedge clk);
    bus.i_bus_en = 1'b1; bus.i_wr_en = 1'b1; bus.i_addr = 32'h30; bus.i_wr_data = 32'h00BA_DBAD; bus.i_byte_en = 4'hF;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.i_bus_en = 1'b0;
    @(posedge clk); #1;
    check("rstw_ack", 32'(bus.o_ack), 32'd0);
    check("rstw_busy", 32'(bus.o_busy), 32'd0);
    check("rstw_rd", bus.o_rd_data, 32'd0);
    @(posedge clk); #1;
    check("rstw_ack2", 32'(bus.o_ack), 32'd0);
    @(negedge clk) rst = 1'b1;
    last_rd = 32'd0;
    rd("r_rstw", 32'h30, 32'h1234_5678);

    @(negedge clk);
    bus.i_bus_en = 1'b1; bus.i_wr_en = 1'b1; bus.i_addr = 32'h40; bus.i_wr_data = 32'h1111_1111; bus.i_byte_en = 4'hF;
    @(posedge clk);
    @(negedge clk);
    bus.i_wr_en = 1'b0; bus.i_addr = 32'h20; bus.i_wr_data = 32'h2222_2222; bus.i_byte_en = 4'h0;
    n = 1;
    do begin @(posedge clk); #1; n++; end while (bus.o_ack !== 1'b1 && n < 20);
    check("chg_lat", 32'(n), 32'd3);
    check("chg_rd_hold", bus.o_rd_data, 32'h1234_5678);
    bus.i_bus_en = 1'b0;
    @(posedge clk); #1;
    rd("r_chg40", 32'h40, 32'h1111_1111);
    rd("r_chg20", 32'h20, 32'h11BB_33DD);

    @(negedge clk);
    bus.i_bus_en = 1'b1; bus.i_wr_en = 1'b0; bus.i_addr = 32'h10; bus.i_byte_en = 4'h0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (bus.o_ack !== 1'b1 && n < 20);
    check("b2b_lat1", 32'(n), 32'd3);
    @(posedge clk); #1;
    check("b2b_gap", 32'(bus.o_ack), 32'd0);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (bus.o_ack !== 1'b1 && n < 20);
    check("b2b_lat2", 32'(n), 32'd3);
    check("b2b_rd", bus.o_rd_data, 32'h0000_00A5);
    bus.i_bus_en = 1'b0;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
